// File: rtl/pipe_fixed_point_acc.sv
`timescale 1ns/1ps
// Saturating per-frame accumulator of signed fixed-point samples; result held until accepted.
// Optional upstream overflow input enabled by FIXED_ACC_INOVF_EN.
module pipe_fixed_point_acc #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 16,
  parameter int WOF   = 8,
  parameter int WCNT  = 9,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [WII+WIF-1:0]   in,
`ifdef FIXED_ACC_INOVF_EN
  input  logic                 in_overflow,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WOI+WOF-1:0]   out,
  output logic                 out_overflow,
  output logic [WCNT-1:0]      out_count
);

  localparam int WO  = WOI + WOF;
  localparam int WFX = (WOF > WIF) ? WOF : WIF;
  // Two spare integer bits leave room for the rounding carry before the clamp.
  localparam int EW  = WOI + WFX + 2;
  localparam int LSH = WFX - WIF;
  localparam int RSH = WFX - WOF;
  localparam logic [EW-1:0] RND = (ROUND != 0) ? ((EW'(1) << RSH) >> 1) : '0;
  localparam logic signed [EW-1:0] MAX_E = (EW'(1) << (WO - 1)) - EW'(1);

  typedef enum logic {ACC, HOLD} state_t;
  state_t state;

  logic [WO-1:0]         acc;
  logic [WCNT-1:0]       cnt;
  logic                  sticky;

  logic signed [EW-1:0]  ext;
  logic signed [EW-1:0]  rnd_sh;
  logic [WO-1:0]         aligned;
  logic [WO:0]           sum;
  logic                  sat_hi;
  logic                  sat_lo;
  logic [WO-1:0]         sum_sat;
  logic                  beat_ovf;
  logic [WCNT-1:0]       cnt_nxt;
  logic                  accept;

  assign in_ready = (state == ACC);
  assign accept   = in_valid && in_ready;

  always_comb begin
    ext     = EW'($signed(in)) <<< LSH;
    rnd_sh  = (ext + $signed(RND)) >>> RSH;
    aligned = (rnd_sh > MAX_E) ? MAX_E[WO-1:0] : rnd_sh[WO-1:0];

    sum     = {acc[WO-1], acc} + {aligned[WO-1], aligned};
    sat_hi  = !sum[WO] &&  sum[WO-1];
    sat_lo  =  sum[WO] && !sum[WO-1];
    if (sat_hi)
      sum_sat = {1'b0, {(WO-1){1'b1}}};
    else if (sat_lo)
      sum_sat = {1'b1, {(WO-1){1'b0}}};
    else
      sum_sat = sum[WO-1:0];

`ifdef FIXED_ACC_INOVF_EN
    beat_ovf = sat_hi || sat_lo || in_overflow;
`else
    beat_ovf = sat_hi || sat_lo;
`endif
    cnt_nxt = (&cnt) ? cnt : cnt + WCNT'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACC;
      acc          <= '0;
      sticky       <= 1'b0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out          <= '0;
      out_overflow <= 1'b0;
      out_count    <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (in_last) begin
              out          <= sum_sat;
              out_count    <= cnt_nxt;
              out_overflow <= sticky || beat_ovf;
              out_valid    <= 1'b1;
              acc          <= '0;
              cnt          <= '0;
              sticky       <= 1'b0;
              state        <= HOLD;
            end else begin
              acc          <= sum_sat;
              cnt          <= cnt_nxt;
              sticky       <= sticky || beat_ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
